// File: rtl/vote_pkg.sv
// Shared types and defaults for the vote accumulation/collection stage.
package vote_pkg;

    // Collector phases: gather leaves, present totals for one cycle, then freeze them.
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        EMIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Extra freeze cycles that cover the downstream label pipe and mul-add latency.
    localparam int HOLD_EXTRA_DEF = 4;

    // Default label count and counter width.
    localparam int N_LABELS_DEF  = 10;
    localparam int RES_WIDTH_DEF = 16;

    // One counter per label at the default geometry.
    typedef logic [RES_WIDTH_DEF-1:0] label_cnt_arr_t [N_LABELS_DEF];

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; one per class label.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    // Clear wins over increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_inc && (o_cnt != '1)) begin
            o_cnt <= o_cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vote_accum_collect.sv
// Collects per-tree leaf results of one sample, presents the totals with a
// one-cycle valid, then freezes them while the vote buffer consumes them.
module vote_accum_collect
    import vote_pkg::*;
#(
    parameter int N_LABELS       = 10,
    parameter int N_LABELS_WIDTH = 4,
    parameter int RES_WIDTH      = 16,
    parameter int BRAM_AWIDTH    = 14,
    parameter int TREE_CNT_WIDTH = 10,
    parameter int HOLD_EXTRA     = HOLD_EXTRA_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_start,
    input  logic                          i_is_clf,
    input  logic [N_LABELS_WIDTH-1:0]     i_n_labels,
    input  logic [TREE_CNT_WIDTH-1:0]     i_n_trees,
    input  logic [BRAM_AWIDTH-1:0]        i_n_slots,
    input  logic                          i_leaf_vld,
    output logic                          o_leaf_rdy,
    input  logic [N_LABELS_WIDTH-1:0]     i_leaf_label,
    input  logic [RES_WIDTH-1:0]          i_leaf_value,
    output logic [N_LABELS*RES_WIDTH-1:0] o_clf_accum,
    output logic [RES_WIDTH-1:0]          o_rgs_accum,
    output logic                          o_accum_vld,
    output logic [BRAM_AWIDTH-1:0]        o_vote_slot,
    output logic                          o_bad_label,
    output logic                          o_busy
);

    localparam int HOLD_W = N_LABELS_WIDTH + 4;

    state_t                      r_state;
    state_t                      w_nextState;
    logic [TREE_CNT_WIDTH-1:0]   r_treeCnt;
    logic [HOLD_W-1:0]           r_holdCnt;
    logic [RES_WIDTH-1:0]        r_rgsAccum;
    logic [BRAM_AWIDTH-1:0]      r_voteSlot;
    logic                        r_badLabel;

    logic                        w_accept;
    logic                        w_lastLeaf;
    logic                        w_holdDone;
    logic                        w_clearCnt;
    logic                        w_slotLast;
    logic [TREE_CNT_WIDTH-1:0]   w_nTrees;
    logic [TREE_CNT_WIDTH-1:0]   w_treeNext;
    logic [BRAM_AWIDTH-1:0]      w_nSlots;
    logic [HOLD_W-1:0]           w_holdLoad;
    logic [RES_WIDTH-1:0]        w_labelCnt [N_LABELS];

    // A zero tree or slot count behaves like one so the sample and slot always advance.
    assign w_nTrees   = (i_n_trees == '0) ? TREE_CNT_WIDTH'(1) : i_n_trees;
    assign w_nSlots   = (i_n_slots == '0) ? BRAM_AWIDTH'(1) : i_n_slots;
    assign w_treeNext = r_treeCnt + TREE_CNT_WIDTH'(1);
    assign w_slotLast = (r_voteSlot >= (w_nSlots - BRAM_AWIDTH'(1)));

    // The hold count is loaded when the last leaf lands, so the EMIT cycle is part of the freeze.
    assign w_holdLoad = HOLD_W'(i_n_labels) + HOLD_W'(HOLD_EXTRA) - HOLD_W'(1);

    assign o_leaf_rdy  = (r_state == ACCUM);
    assign w_accept    = i_leaf_vld & o_leaf_rdy & ~i_start;
    assign w_lastLeaf  = w_accept & (w_treeNext == w_nTrees);
    assign w_holdDone  = (r_state != ACCUM) && (r_holdCnt == '0);
    assign w_clearCnt  = i_start | w_holdDone;

    assign o_accum_vld = (r_state == EMIT);
    assign o_rgs_accum = r_rgsAccum;
    assign o_vote_slot = r_voteSlot;
    assign o_bad_label = r_badLabel;
    assign o_busy      = (r_state != ACCUM) || (r_treeCnt != '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; a start pulse always returns to ACCUM.
    always_comb begin
        w_nextState = r_state;
        if (i_start) begin
            w_nextState = ACCUM;
        end else begin
            case (r_state)
                ACCUM: if (w_lastLeaf) w_nextState = EMIT;
                EMIT:  w_nextState = w_holdDone ? ACCUM : HOLD;
                HOLD:  if (w_holdDone) w_nextState = ACCUM;
                default: w_nextState = ACCUM;
            endcase
        end
    end

    // Tree count, hold timer, regression sum, vote slot and bad-label flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_treeCnt  <= '0;
            r_holdCnt  <= '0;
            r_rgsAccum <= '0;
            r_voteSlot <= '0;
            r_badLabel <= 1'b0;
        end else if (i_start) begin
            r_treeCnt  <= '0;
            r_holdCnt  <= '0;
            r_rgsAccum <= '0;
            r_voteSlot <= '0;
            r_badLabel <= 1'b0;
        end else begin
            r_badLabel <= w_accept & i_is_clf & (i_leaf_label >= i_n_labels);
            if (w_holdDone) begin
                r_treeCnt  <= '0;
                r_rgsAccum <= '0;
                r_voteSlot <= w_slotLast ? '0 : (r_voteSlot + BRAM_AWIDTH'(1));
            end else if (w_accept) begin
                r_treeCnt <= w_treeNext;
                if (!i_is_clf) begin
                    r_rgsAccum <= r_rgsAccum + i_leaf_value;
                end
            end
            if (w_lastLeaf) begin
                r_holdCnt <= w_holdLoad;
            end else if ((r_state != ACCUM) && (r_holdCnt != '0)) begin
                r_holdCnt <= r_holdCnt - HOLD_W'(1);
            end
        end
    end

    // One saturating counter per label; labels outside the active range read as zero.
    genvar k;
    generate
        for (k = 0; k < N_LABELS; k++) begin : g_label
            localparam logic [N_LABELS_WIDTH-1:0] LBL = N_LABELS_WIDTH'(k);
            logic w_inc;
            logic w_active;

            assign w_active = (LBL < i_n_labels);
            assign w_inc    = w_accept & i_is_clf & (i_leaf_label == LBL) & w_active;

            sat_counter #(
                .WIDTH (RES_WIDTH)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .i_clr (w_clearCnt),
                .i_inc (w_inc),
                .o_cnt (w_labelCnt[k])
            );

            assign o_clf_accum[k*RES_WIDTH +: RES_WIDTH] = w_active ? w_labelCnt[k] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_vote_accum_collect.sv
// Self-checking bench for vote_accum_collect: directed scenarios plus random
// samples compared against a per-sample tally model.
module tb_vote_accum_collect;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         isClf;
    logic [3:0]   nLabels;
    logic [9:0]   nTrees;
    logic [13:0]  nSlots;
    logic         leafVld;
    logic         leafRdy;
    logic [3:0]   leafLabel;
    logic [15:0]  leafValue;
    logic [159:0] clfAccum;
    logic [15:0]  rgsAccum;
    logic         accumVld;
    logic [13:0]  voteSlot;
    logic         badLabel;
    logic         busy;

    logic         satVld;
    logic         satRdy;
    logic [39:0]  satClf;
    logic [3:0]   satRgs;
    logic         satAccumVld;
    logic [13:0]  satSlot;
    logic         satBad;
    logic         satBusy;

    int assertCount = 0;
    int failCount   = 0;
    int modelSlot   = 0;
    int labelQ[$];
    int valueQ[$];

    always #5 clk = ~clk;

    vote_accum_collect dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_is_clf     (isClf),
        .i_n_labels   (nLabels),
        .i_n_trees    (nTrees),
        .i_n_slots    (nSlots),
        .i_leaf_vld   (leafVld),
        .o_leaf_rdy   (leafRdy),
        .i_leaf_label (leafLabel),
        .i_leaf_value (leafValue),
        .o_clf_accum  (clfAccum),
        .o_rgs_accum  (rgsAccum),
        .o_accum_vld  (accumVld),
        .o_vote_slot  (voteSlot),
        .o_bad_label  (badLabel),
        .o_busy       (busy)
    );

    vote_accum_collect #(
        .RES_WIDTH (4)
    ) dutSat (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (1'b0),
        .i_is_clf     (1'b1),
        .i_n_labels   (4'd3),
        .i_n_trees    (10'd20),
        .i_n_slots    (14'd1),
        .i_leaf_vld   (satVld),
        .o_leaf_rdy   (satRdy),
        .i_leaf_label (4'd0),
        .i_leaf_value (4'd0),
        .o_clf_accum  (satClf),
        .o_rgs_accum  (satRgs),
        .o_accum_vld  (satAccumVld),
        .o_vote_slot  (satSlot),
        .o_bad_label  (satBad),
        .o_busy       (satBusy)
    );

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic vld, input int label, input int value);
        leafVld   = vld;
        leafLabel = label[3:0];
        leafValue = value[15:0];
    endtask

    // Feeds labelQ/valueQ as one sample and checks the emitted totals and the freeze window.
    task automatic runSample(input bit clf, input int nl, input int nt, input int ns, input bit gaps);
        int           effT;
        int           c[16];
        int           rdyLow;
        logic [159:0] expClf;
        logic [15:0]  expRgs;
        logic [13:0]  expSlot;
        int           v;
        effT = (nt == 0) ? 1 : nt;
        foreach (c[j]) c[j] = 0;
        expRgs = '0;
        for (int i = 0; i < effT; i++) begin
            if (clf && labelQ[i] < nl) c[labelQ[i]]++;
            v = valueQ[i];
            if (!clf) expRgs = expRgs + v[15:0];
        end
        expClf = '0;
        for (int k = 0; k < nl; k++) begin
            v = c[k];
            expClf[k*16 +: 16] = (v > 65535) ? 16'hFFFF : v[15:0];
        end
        v       = modelSlot;
        expSlot = v[13:0];
        isClf   = clf;
        nLabels = nl[3:0];
        nTrees  = nt[9:0];
        nSlots  = ns[13:0];
        for (int i = 0; i < effT; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            checkOutput("rdy_in_accum", leafRdy, 1);
            applyStimulus(1'b1, labelQ[i], valueQ[i]);
            @(negedge clk);
            applyStimulus(1'b0, 0, 0);
            checkOutput("bad_label", badLabel, (clf && labelQ[i] >= nl) ? 1 : 0);
            if (i != effT - 1) checkOutput("no_early_vld", accumVld, 0);
        end
        checkOutput("accum_vld", accumVld, 1);
        checkOutput("clf_accum", clfAccum, expClf);
        checkOutput("rgs_accum", rgsAccum, expRgs);
        checkOutput("vote_slot", voteSlot, expSlot);
        checkOutput("rdy_low_emit", leafRdy, 0);
        rdyLow = 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (leafRdy === 1'b1) break;
            rdyLow++;
            checkOutput("hold_stable", {accumVld, voteSlot, rgsAccum, clfAccum},
                        {1'b0, expSlot, expRgs, expClf});
        end
        checkOutput("rdy_low_cycles", rdyLow, nl + 4);
        modelSlot = (modelSlot + 1) % ((ns == 0) ? 1 : ns);
        checkOutput("slot_advance", voteSlot, modelSlot);
        checkOutput("cleared_after_hold", {busy, rgsAccum, clfAccum}, 0);
        labelQ.delete();
        valueQ.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        isClf = 1'b1;
        nLabels = 4'd3;
        nTrees = 10'd5;
        nSlots = 14'd2;
        satVld = 1'b0;
        applyStimulus(1'b0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {accumVld, badLabel, voteSlot, rgsAccum, clfAccum}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_rdy", leafRdy, 1);
        checkOutput("reset_busy", busy, 0);
        modelSlot = 0;

        // Classification with back-to-back leaves
        labelQ = '{0, 2, 2, 1, 2};
        valueQ = '{0, 0, 0, 0, 0};
        runSample(1'b1, 3, 5, 2, 1'b0);

        // Regression sum with wrap-around
        labelQ = '{0, 0, 0};
        valueQ = '{'h0005, 'hFFFE, 'h0010};
        runSample(1'b0, 3, 3, 2, 1'b0);

        // Out-of-range label still counts as a tree; slot wraps back to 0
        labelQ = '{7, 1, 0};
        valueQ = '{0, 0, 0};
        runSample(1'b1, 3, 3, 2, 1'b0);

        // Zero tree count behaves like one
        labelQ = '{1};
        valueQ = '{0};
        runSample(1'b1, 3, 0, 2, 1'b0);

        // Start pulse returns the slot to 0 before switching slot wrap
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        modelSlot = 0;
        checkOutput("start_slot", voteSlot, 0);

        // Random samples with idle gaps
        for (int s = 0; s < 8; s++) begin
            bit clf;
            int nl;
            int nt;
            clf = 1'($urandom_range(0, 1));
            nl  = $urandom_range(1, 10);
            nt  = $urandom_range(1, 8);
            for (int i = 0; i < nt; i++) begin
                labelQ.push_back($urandom_range(0, 11));
                valueQ.push_back(int'($urandom));
            end
            runSample(clf, nl, nt, 3, 1'b1);
        end

        // Start pulse during HOLD with a simultaneous leaf
        isClf = 1'b1;
        nLabels = 4'd3;
        nTrees = 10'd2;
        applyStimulus(1'b1, 1, 0);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 0, 0);
        checkOutput("pre_start_vld", accumVld, 1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        applyStimulus(1'b1, 2, 0);
        @(negedge clk);
        start = 1'b0;
        applyStimulus(1'b0, 0, 0);
        modelSlot = 0;
        checkOutput("start_hold_rdy", leafRdy, 1);
        checkOutput("start_hold_clear", {accumVld, voteSlot, busy, rgsAccum, clfAccum}, 0);
        @(negedge clk);
        checkOutput("start_hold_no_vld", accumVld, 0);

        // Start pulse in ACCUM drops the simultaneous leaf
        nTrees = 10'd4;
        applyStimulus(1'b1, 0, 0);
        @(negedge clk);
        checkOutput("busy_mid_sample", busy, 1);
        start = 1'b1;
        applyStimulus(1'b1, 1, 0);
        @(negedge clk);
        start = 1'b0;
        applyStimulus(1'b0, 0, 0);
        checkOutput("start_drops_leaf", {busy, clfAccum}, 0);

        labelQ = '{2, 2};
        valueQ = '{0, 0};
        runSample(1'b1, 3, 2, 3, 1'b0);
        labelQ = '{0};
        valueQ = '{0};
        runSample(1'b1, 3, 1, 3, 1'b0);

        // Reset in the middle of accumulation
        nTrees = 10'd5;
        applyStimulus(1'b1, 0, 0);
        @(negedge clk);
        applyStimulus(1'b1, 1, 0);
        @(negedge clk);
        applyStimulus(1'b0, 0, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_accum", {accumVld, badLabel, busy, voteSlot, rgsAccum, clfAccum}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        modelSlot = 0;
        checkOutput("reset_release_rdy", leafRdy, 1);
        checkOutput("reset_release_busy", busy, 0);
        labelQ = '{1, 1, 1, 1, 1};
        valueQ = '{0, 0, 0, 0, 0};
        runSample(1'b1, 3, 5, 3, 1'b0);

        // Narrow counters saturate
        satVld = 1'b1;
        repeat (20) @(negedge clk);
        satVld = 1'b0;
        checkOutput("sat_vld", satAccumVld, 1);
        checkOutput("sat_counter", satClf, 40'h00_0000_000F);

        $display("[TB] stimulus complete");
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/vote_accum_collect.md
Name: vote_accum_collect

Overview:
- Collects per-tree leaf results for one sample and feeds the vote buffer stage directly downstream.
- Classification: counts one vote per accepted leaf label. Regression: sums the leaf values.
- After all trees of a sample are in, it presents the totals together with a 1-cycle valid and the current vote slot. It then holds them stable while the downstream stage scans labels and computes its address.
- Sits between the tree-traversal engines and the vote BRAM accumulator.

Parameters:
- N_LABELS, 10, maximum number of labels.
- N_LABELS_WIDTH, 4, bits to index labels.
- RES_WIDTH, 16, width of each label counter and of the regression sum.
- BRAM_AWIDTH, 14, vote-slot index width.
- TREE_CNT_WIDTH, 10, width of the tree counter.
- HOLD_EXTRA, 4, hold cycles beyond i_n_labels that cover the downstream label pipe and mul-add latency.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  1-cycle pulse; aborts current sample, clears state, slot:=0
- i_is_clf  in  1  1=classification, 0=regression; static while running
- i_n_labels  in  N_LABELS_WIDTH  active label count, 1..N_LABELS
- i_n_trees  in  TREE_CNT_WIDTH  leaves per sample; 0 treated as 1
- i_n_slots  in  BRAM_AWIDTH  slot wrap count; 0 treated as 1
- i_leaf_vld  in  1  leaf result valid
- o_leaf_rdy  out  1  leaf accepted when i_leaf_vld & o_leaf_rdy
- i_leaf_label  in  N_LABELS_WIDTH  class label (clf mode)
- i_leaf_value  in  RES_WIDTH  leaf value (rgs mode)
- o_clf_accum  out  N_LABELS*RES_WIDTH  label counters; label k at [k*RES_WIDTH +: RES_WIDTH]
- o_rgs_accum  out  RES_WIDTH  regression sum
- o_accum_vld  out  1  1-cycle pulse, totals complete
- o_vote_slot  out  BRAM_AWIDTH  slot of the presented sample
- o_bad_label  out  1  1-cycle pulse when an accepted label is >= i_n_labels
- o_busy  out  1  state != ACCUM or tree_cnt != 0

Behaviour:
- Reset (async, rst_n=0):
  - state=ACCUM; all counters, o_rgs_accum and o_vote_slot = 0.
  - o_accum_vld=0, o_bad_label=0, o_leaf_rdy=1 after release.
- States:
  - ACCUM: o_leaf_rdy=1. Each accepted leaf increments tree_cnt.
    - clf, label < i_n_labels: counter[label]++, saturating at 2^RES_WIDTH-1.
    - clf, label >= i_n_labels: no counter change; the tree still counts; o_bad_label pulses next cycle.
    - rgs: o_rgs_accum += i_leaf_value, two's-complement wrap to RES_WIDTH.
    - Accepting leaf number i_n_trees -> EMIT.
  - EMIT (1 cycle): o_accum_vld=1; outputs include the last leaf. Latency: last leaf accepted in cycle T -> o_accum_vld in T+1. Then -> HOLD with hold_cnt = i_n_labels + HOLD_EXTRA - 1.
  - HOLD: o_leaf_rdy=0. o_clf_accum, o_rgs_accum and o_vote_slot stay constant. hold_cnt decrements. When hold_cnt==0:
    - counters, sum and tree_cnt clear;
    - o_vote_slot increments, wrapping to 0 after i_n_slots-1;
    - -> ACCUM.
  - Consequence: o_leaf_rdy is 0 from T+1 through T+1+i_n_labels+HOLD_EXTRA-1, and is 1 again at T+1+i_n_labels+HOLD_EXTRA.
- i_start:
  - Has priority over every state and over a simultaneous leaf, which is dropped.
  - Next cycle: ACCUM, everything cleared, slot=0, no o_accum_vld.
- i_n_trees=1: every accepted leaf gives an EMIT.
- Mode or length inputs changing mid-sample: undefined. Software must pulse i_start afterwards.
- Reset mid-HOLD: outputs return to reset values immediately; no valid pulse.
- o_clf_accum entries at or above i_n_labels read 0.

Decomposition:
- Package vote_pkg:
  - state enum {ACCUM, EMIT, HOLD};
  - HOLD_EXTRA default constant;
  - label-counter array typedef.
- Sub-module sat_counter: RES_WIDTH saturating incrementer with sync clear. One instance per label in a generate loop.
- FSM, tree counter, slot counter and regression adder stay in the top module.

Test Plan:
- clf, n_labels=3, n_trees=5, labels 0,2,2,1,2 back-to-back -> o_accum_vld one cycle after the 5th leaf with counters {1,1,3}, slot 0; o_leaf_rdy=0 for exactly 7 cycles.
- rgs, n_trees=3, values 0x0005, 0xFFFE, 0x0010 -> o_rgs_accum=0x0013 with the pulse; next sample starts from 0.
- n_slots=2, three samples -> o_vote_slot 0,1,0; vld held low while o_leaf_rdy=0 -> no acceptance, counts unchanged.
- clf label 7 with n_labels=3 -> o_bad_label pulses; counters unchanged; tree still counted, so the pulse arrives after n_trees leaves.
- RES_WIDTH=4, 20 leaves of label 0 -> counter 0 saturates at 15.
- i_start during HOLD, and separately rst_n low mid-ACCUM -> state cleared, slot 0, no o_accum_vld, o_leaf_rdy=1 the next cycle.
